// File: rtl/brr_voice_bank.sv
// Time-multiplexed BRR (4-bit ADPCM) decoder: one frame per sample_tick, voices served
// in ascending order through a single shared 8-bit RAM read port.
module brr_voice_bank #(
    parameter int NUM_VOICES = 8,
    parameter int VIDX_W     = 3,
    parameter int PITCH_W    = 14
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sample_tick,
    input  logic [NUM_VOICES-1:0]    key_on,
    input  logic [NUM_VOICES-1:0]    key_off,
    input  logic                     cfg_write,
    input  logic [VIDX_W-1:0]        cfg_voice,
    input  logic [15:0]              cfg_start_address,
    input  logic [15:0]              cfg_loop_address,
    input  logic [PITCH_W-1:0]       cfg_pitch,
    output logic [15:0]              ram_address,
    output logic                     ram_read_request,
    input  logic [7:0]               ram_data,
    input  logic                     ram_data_valid,
    output logic                     out_valid,
    output logic [VIDX_W-1:0]        out_voice,
    output logic signed [15:0]       out_sample,
    output logic [NUM_VOICES-1:0]    voice_active,
    output logic [NUM_VOICES-1:0]    reached_end,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_SLOT, S_ADVANCE, S_FETCH_HDR, S_FETCH_DATA, S_DECODE, S_EMIT, S_FRAME_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [VIDX_W-1:0]      vidx_q, vidx_d;
    logic [PITCH_W-1:0]     slot_pitch_q, slot_pitch_d;
    logic [7:0]             byte_q, byte_d;

    logic [15:0]            start_q [NUM_VOICES];
    logic [15:0]            start_d [NUM_VOICES];
    logic [15:0]            loop_q  [NUM_VOICES];
    logic [15:0]            loop_d  [NUM_VOICES];
    logic [PITCH_W-1:0]     pitch_q [NUM_VOICES];
    logic [PITCH_W-1:0]     pitch_d [NUM_VOICES];
    logic [15:0]            base_q  [NUM_VOICES];
    logic [15:0]            base_d  [NUM_VOICES];
    logic [7:0]             hdr_q   [NUM_VOICES];
    logic [7:0]             hdr_d   [NUM_VOICES];
    logic [3:0]             nib_q   [NUM_VOICES];
    logic [3:0]             nib_d   [NUM_VOICES];
    logic [14:0]            pos_q   [NUM_VOICES];
    logic [14:0]            pos_d   [NUM_VOICES];
    logic signed [15:0]     s1_q    [NUM_VOICES];
    logic signed [15:0]     s1_d    [NUM_VOICES];
    logic signed [15:0]     s2_q    [NUM_VOICES];
    logic signed [15:0]     s2_d    [NUM_VOICES];
    logic [NUM_VOICES-1:0]  hdr_ok_q, hdr_ok_d;
    logic [NUM_VOICES-1:0]  pend_on_q, pend_on_d;
    logic [NUM_VOICES-1:0]  pend_off_q, pend_off_d;
    logic [NUM_VOICES-1:0]  active_q, active_d;
    logic [NUM_VOICES-1:0]  end_q, end_d;

    logic [15:0]            addr_q, addr_d;
    logic                   req_q, req_d;
    logic                   out_valid_q, out_valid_d;
    logic [VIDX_W-1:0]      out_voice_q, out_voice_d;
    logic signed [15:0]     out_sample_q, out_sample_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    logic [14:0]            pos_sum_s;
    logic [14:0]            pos_rem_s;
    logic [3:0]             nibble_s;
    logic [15:0]            new_base_s;
    logic                   new_ok_s;
    logic                   stop_s;

    function automatic logic [15:0] data_addr(input logic [15:0] base, input logic [3:0] nib);
        return base + 16'd1 + {13'd0, nib[3:1]};
    endfunction

    function automatic logic signed [15:0] brr_decode(
        input logic [3:0]         nib,
        input logic [7:0]         hdr,
        input logic signed [15:0] p1,
        input logic signed [15:0] p2
    );
        logic signed [31:0] n32, r, a, b, acc;
        n32 = {{28{nib[3]}}, nib};
        a   = {{16{p1[15]}}, p1};
        b   = {{16{p2[15]}}, p2};
        if (hdr[7:4] <= 4'd12) begin
            r = (n32 <<< hdr[7:4]) >>> 1;
        end else begin
            r = nib[3] ? -32'sd2048 : 32'sd0;
        end
        case (hdr[3:2])
            2'd0:    acc = r;
            2'd1:    acc = r + a + ((-a) >>> 4);
            2'd2:    acc = r + (a <<< 1) + ((-(a * 32'sd3)) >>> 5) - b + (b >>> 4);
            2'd3:    acc = r + (a <<< 1) + ((-(a * 32'sd13)) >>> 6) - b + ((b * 32'sd3) >>> 4);
            default: acc = r;
        endcase
        if (acc > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (acc < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return acc[15:0];
        end
    endfunction

    function automatic logic signed [15:0] interp(
        input logic signed [15:0] p1,
        input logic signed [15:0] p2,
        input logic [11:0]        frac
    );
        logic signed [31:0] w1, w2, e1, e2, acc;
        w1  = $signed({20'd0, frac});
        w2  = 32'sd4096 - w1;
        e1  = {{16{p1[15]}}, p1};
        e2  = {{16{p2[15]}}, p2};
        acc = (e2 * w2 + e1 * w1) >>> 12;
        return acc[15:0];
    endfunction

    // Next-state logic for the frame sequencer and all per-voice state.
    always_comb begin
        state_d      = state_q;
        vidx_d       = vidx_q;
        slot_pitch_d = slot_pitch_q;
        byte_d       = byte_q;
        start_d      = start_q;
        loop_d       = loop_q;
        pitch_d      = pitch_q;
        base_d       = base_q;
        hdr_d        = hdr_q;
        nib_d        = nib_q;
        pos_d        = pos_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        hdr_ok_d     = hdr_ok_q;
        pend_on_d    = pend_on_q;
        pend_off_d   = pend_off_q;
        active_d     = active_q;
        end_d        = end_q;
        addr_d       = addr_q;
        req_d        = req_q;
        out_valid_d  = 1'b0;
        out_voice_d  = out_voice_q;
        out_sample_d = out_sample_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        pos_sum_s    = pos_q[vidx_q] + 15'(slot_pitch_q);
        pos_rem_s    = pos_q[vidx_q] - 15'd4096;
        nibble_s     = nib_q[vidx_q][0] ? byte_q[3:0] : byte_q[7:4];
        new_base_s   = base_q[vidx_q];
        new_ok_s     = hdr_ok_q[vidx_q];
        stop_s       = 1'b0;

        if (cfg_write) begin
            start_d[cfg_voice] = cfg_start_address;
            loop_d[cfg_voice]  = cfg_loop_address;
            pitch_d[cfg_voice] = cfg_pitch;
        end else begin
            start_d = start_q;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_tick && !busy_q) begin
                    state_d = S_SLOT;
                    vidx_d  = '0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_SLOT: begin
                slot_pitch_d         = pitch_q[vidx_q];
                pend_on_d[vidx_q]    = 1'b0;
                pend_off_d[vidx_q]   = 1'b0;
                if (pend_on_q[vidx_q]) begin
                    base_d[vidx_q]   = start_q[vidx_q];
                    nib_d[vidx_q]    = 4'd0;
                    pos_d[vidx_q]    = 15'd0;
                    s1_d[vidx_q]     = 16'sd0;
                    s2_d[vidx_q]     = 16'sd0;
                    hdr_ok_d[vidx_q] = 1'b0;
                    end_d[vidx_q]    = 1'b0;
                    active_d[vidx_q] = 1'b1;
                    state_d          = S_ADVANCE;
                end else if (pend_off_q[vidx_q]) begin
                    active_d[vidx_q] = 1'b0;
                    s1_d[vidx_q]     = 16'sd0;
                    s2_d[vidx_q]     = 16'sd0;
                    state_d          = S_EMIT;
                end else begin
                    state_d = active_q[vidx_q] ? S_ADVANCE : S_EMIT;
                end
            end
            S_ADVANCE: begin
                pos_d[vidx_q] = pos_sum_s;
                if (pos_sum_s < 15'd4096) begin
                    state_d = S_EMIT;
                end else if (!hdr_ok_q[vidx_q]) begin
                    state_d = S_FETCH_HDR;
                    addr_d  = base_q[vidx_q];
                    req_d   = 1'b1;
                end else begin
                    state_d = S_FETCH_DATA;
                    addr_d  = data_addr(base_q[vidx_q], nib_q[vidx_q]);
                    req_d   = 1'b1;
                end
            end
            S_FETCH_HDR: begin
                if (ram_data_valid) begin
                    hdr_d[vidx_q]    = ram_data;
                    hdr_ok_d[vidx_q] = 1'b1;
                    addr_d           = data_addr(base_q[vidx_q], nib_q[vidx_q]);
                    state_d          = S_FETCH_DATA;
                end else begin
                    state_d = S_FETCH_HDR;
                end
            end
            S_FETCH_DATA: begin
                if (ram_data_valid) begin
                    byte_d  = ram_data;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH_DATA;
                end
            end
            S_DECODE: begin
                s2_d[vidx_q]  = s1_q[vidx_q];
                s1_d[vidx_q]  = brr_decode(nibble_s, hdr_q[vidx_q], s1_q[vidx_q], s2_q[vidx_q]);
                nib_d[vidx_q] = nib_q[vidx_q] + 4'd1;
                pos_d[vidx_q] = pos_rem_s;
                // Block end: continue to the next block, jump to the loop point, or stop.
                if (nib_q[vidx_q] == 4'd15) begin
                    if (!hdr_q[vidx_q][0]) begin
                        new_base_s = base_q[vidx_q] + 16'd9;
                        new_ok_s   = 1'b0;
                    end else if (hdr_q[vidx_q][1]) begin
                        end_d[vidx_q] = 1'b1;
                        new_base_s    = loop_q[vidx_q];
                        new_ok_s      = 1'b0;
                    end else begin
                        end_d[vidx_q]    = 1'b1;
                        active_d[vidx_q] = 1'b0;
                        s1_d[vidx_q]     = 16'sd0;
                        s2_d[vidx_q]     = 16'sd0;
                        stop_s           = 1'b1;
                    end
                end else begin
                    stop_s = 1'b0;
                end
                base_d[vidx_q]   = new_base_s;
                hdr_ok_d[vidx_q] = new_ok_s;
                if (stop_s || (pos_rem_s < 15'd4096)) begin
                    state_d = S_EMIT;
                end else if (!new_ok_s) begin
                    state_d = S_FETCH_HDR;
                    addr_d  = new_base_s;
                    req_d   = 1'b1;
                end else begin
                    state_d = S_FETCH_DATA;
                    addr_d  = data_addr(new_base_s, nib_q[vidx_q] + 4'd1);
                    req_d   = 1'b1;
                end
            end
            S_EMIT: begin
                out_valid_d  = 1'b1;
                out_voice_d  = vidx_q;
                out_sample_d = active_q[vidx_q]
                             ? interp(s1_q[vidx_q], s2_q[vidx_q], pos_q[vidx_q][11:0])
                             : 16'sd0;
                if (vidx_q == VIDX_W'(NUM_VOICES - 1)) begin
                    state_d = S_FRAME_DONE;
                end else begin
                    vidx_d  = vidx_q + VIDX_W'(1);
                    state_d = S_SLOT;
                end
            end
            S_FRAME_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Key-on beats a simultaneous key-off; new pulses survive the slot that clears them.
        pend_on_d  = pend_on_d | key_on;
        pend_off_d = pend_off_d | (key_off & ~key_on);
        if (sample_tick && busy_q) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vidx_q       <= '0;
            slot_pitch_q <= '0;
            byte_q       <= 8'd0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                start_q[i] <= 16'd0;
                loop_q[i]  <= 16'd0;
                pitch_q[i] <= '0;
                base_q[i]  <= 16'd0;
                hdr_q[i]   <= 8'd0;
                nib_q[i]   <= 4'd0;
                pos_q[i]   <= 15'd0;
                s1_q[i]    <= 16'sd0;
                s2_q[i]    <= 16'sd0;
            end
            hdr_ok_q     <= '0;
            pend_on_q    <= '0;
            pend_off_q   <= '0;
            active_q     <= '0;
            end_q        <= '0;
            addr_q       <= 16'd0;
            req_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_voice_q  <= '0;
            out_sample_q <= 16'sd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vidx_q       <= vidx_d;
            slot_pitch_q <= slot_pitch_d;
            byte_q       <= byte_d;
            start_q      <= start_d;
            loop_q       <= loop_d;
            pitch_q      <= pitch_d;
            base_q       <= base_d;
            hdr_q        <= hdr_d;
            nib_q        <= nib_d;
            pos_q        <= pos_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            hdr_ok_q     <= hdr_ok_d;
            pend_on_q    <= pend_on_d;
            pend_off_q   <= pend_off_d;
            active_q     <= active_d;
            end_q        <= end_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            out_valid_q  <= out_valid_d;
            out_voice_q  <= out_voice_d;
            out_sample_q <= out_sample_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ram_address      = addr_q;
    assign ram_read_request = req_q;
    assign out_valid        = out_valid_q;
    assign out_voice        = out_voice_q;
    assign out_sample       = out_sample_q;
    assign voice_active     = active_q;
    assign reached_end      = end_q;
    assign frame_done       = frame_done_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_brr_voice_bank.sv
// Scoreboard bench for brr_voice_bank: a frame-level reference model predicts RAM
// addresses, output samples and per-frame flags; monitors compare as the DUT presents them.
module tb_brr_voice_bank;
    localparam int NV = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              sample_tick = 1'b0;
    logic [NV-1:0]     key_on = '0;
    logic [NV-1:0]     key_off = '0;
    logic              cfg_write = 1'b0;
    logic [2:0]        cfg_voice = '0;
    logic [15:0]       cfg_start_address = '0;
    logic [15:0]       cfg_loop_address = '0;
    logic [13:0]       cfg_pitch = '0;
    logic [15:0]       ram_address;
    logic              ram_read_request;
    logic [7:0]        ram_data = '0;
    logic              ram_data_valid = 1'b0;
    logic              out_valid;
    logic [2:0]        out_voice;
    logic signed [15:0] out_sample;
    logic [NV-1:0]     voice_active;
    logic [NV-1:0]     reached_end;
    logic              frame_done;
    logic              busy;
    logic              overrun;

    brr_voice_bank #(.NUM_VOICES(NV), .VIDX_W(3), .PITCH_W(14)) dut (
        .clock(clock), .reset(reset), .sample_tick(sample_tick),
        .key_on(key_on), .key_off(key_off),
        .cfg_write(cfg_write), .cfg_voice(cfg_voice),
        .cfg_start_address(cfg_start_address), .cfg_loop_address(cfg_loop_address),
        .cfg_pitch(cfg_pitch),
        .ram_address(ram_address), .ram_read_request(ram_read_request),
        .ram_data(ram_data), .ram_data_valid(ram_data_valid),
        .out_valid(out_valid), .out_voice(out_voice), .out_sample(out_sample),
        .voice_active(voice_active), .reached_end(reached_end),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [65536];
    int n_checks = 0;
    int n_fail = 0;
    int exp_voice[$];
    int exp_sample[$];
    int exp_addr[$];
    logic [15:0] exp_flags[$];
    int stall_min = 0;
    int stall_max = 0;

    // Reference model state, one entry per voice.
    int m_start[NV], m_loop[NV], m_pitch[NV], m_base[NV], m_hdr[NV], m_nib[NV], m_pos[NV];
    int m_s1[NV], m_s2[NV];
    bit m_loaded[NV], m_pon[NV], m_poff[NV], m_act[NV], m_end[NV];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int decode(input int n, input int hdr, input int s1, input int s2);
        int rng, r, y;
        rng = hdr / 16;
        if (rng <= 12) r = (n * (1 << rng)) >>> 1;
        else r = (n < 0) ? -2048 : 0;
        case ((hdr / 4) % 4)
            0: y = r;
            1: y = r + s1 + ((-s1) >>> 4);
            2: y = r + 2 * s1 + ((-3 * s1) >>> 5) - s2 + (s2 >>> 4);
            default: y = r + 2 * s1 + ((-13 * s1) >>> 6) - s2 + ((3 * s2) >>> 4);
        endcase
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_start[v] = 0; m_loop[v] = 0; m_pitch[v] = 0; m_base[v] = 0; m_hdr[v] = 0;
            m_nib[v] = 0; m_pos[v] = 0; m_s1[v] = 0; m_s2[v] = 0;
            m_loaded[v] = 0; m_pon[v] = 0; m_poff[v] = 0; m_act[v] = 0; m_end[v] = 0;
        end
        exp_voice.delete(); exp_sample.delete(); exp_addr.delete(); exp_flags.delete();
    endtask

    task automatic model_frame();
        int a, n, fr;
        logic [15:0] fl;
        for (int v = 0; v < NV; v++) begin
            if (m_pon[v]) begin
                m_base[v] = m_start[v]; m_nib[v] = 0; m_pos[v] = 0; m_s1[v] = 0; m_s2[v] = 0;
                m_loaded[v] = 0; m_end[v] = 0; m_act[v] = 1;
            end else if (m_poff[v]) begin
                m_act[v] = 0; m_s1[v] = 0; m_s2[v] = 0;
            end
            m_pon[v] = 0; m_poff[v] = 0;
            if (m_act[v]) m_pos[v] += m_pitch[v];
            while (m_act[v] && m_pos[v] >= 4096) begin
                if (!m_loaded[v]) begin
                    exp_addr.push_back(m_base[v]);
                    m_hdr[v] = int'(mem[m_base[v]]);
                    m_loaded[v] = 1;
                end
                a = (m_base[v] + 1 + m_nib[v] / 2) % 65536;
                exp_addr.push_back(a);
                n = (m_nib[v] % 2 == 0) ? int'(mem[a]) / 16 : int'(mem[a]) % 16;
                if (n >= 8) n -= 16;
                a = decode(n, m_hdr[v], m_s1[v], m_s2[v]);
                m_s2[v] = m_s1[v];
                m_s1[v] = a;
                m_pos[v] -= 4096;
                if (m_nib[v] == 15) begin
                    m_nib[v] = 0;
                    if (m_hdr[v] % 2 == 0) begin
                        m_base[v] = (m_base[v] + 9) % 65536; m_loaded[v] = 0;
                    end else if ((m_hdr[v] / 2) % 2 == 1) begin
                        m_end[v] = 1; m_base[v] = m_loop[v]; m_loaded[v] = 0;
                    end else begin
                        m_end[v] = 1; m_act[v] = 0; m_s1[v] = 0; m_s2[v] = 0;
                    end
                end else begin
                    m_nib[v]++;
                end
            end
            fr = m_pos[v] % 4096;
            exp_voice.push_back(v);
            exp_sample.push_back(m_act[v] ? (m_s2[v] * (4096 - fr) + m_s1[v] * fr) >>> 12 : 0);
        end
        for (int v = 0; v < NV; v++) begin
            fl[8 + v] = m_act[v];
            fl[v] = m_end[v];
        end
        exp_flags.push_back(fl);
    endtask

    // RAM responder: random wait states, address-order and address-stability checks.
    int wait_left = 0;
    bit in_txn = 0;
    logic [15:0] txn_addr = '0;
    always @(negedge clock) begin
        if (reset) begin
            ram_data_valid = 1'b0;
            in_txn = 0;
        end else begin
            if (ram_data_valid) begin
                ram_data_valid = 1'b0;
                in_txn = 0;
            end
            if (ram_read_request) begin
                if (!in_txn) begin
                    in_txn = 1;
                    txn_addr = ram_address;
                    wait_left = $urandom_range(stall_max, stall_min);
                    if (exp_addr.size() == 0) check("ram_addr_unexpected", int'(ram_address), -1);
                    else check("ram_addr_order", int'(ram_address), exp_addr.pop_front());
                end else begin
                    check("ram_addr_stable", int'(ram_address), int'(txn_addr));
                end
                if (wait_left == 0) begin
                    ram_data_valid = 1'b1;
                    ram_data = mem[txn_addr];
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Output monitor: pops expectations whenever the DUT presents a sample or ends a frame.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                if (exp_voice.size() == 0) begin
                    check("out_unexpected", int'(out_voice), -1);
                end else begin
                    check("out_voice", int'(out_voice), exp_voice.pop_front());
                    check("out_sample", int'(out_sample), exp_sample.pop_front());
                end
            end
            if (frame_done) begin
                if (exp_flags.size() == 0) check("frame_unexpected", 1, 0);
                else check("flags_active_end", int'({voice_active, reached_end}), int'(exp_flags.pop_front()));
            end
        end
    end

    task automatic run_frame(input int extra_tick_at);
        int cyc;
        bit got;
        model_frame();
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        cyc = 0;
        got = 0;
        while (!got && cyc < 3000) begin
            sample_tick = (cyc == extra_tick_at);
            @(negedge clock);
            cyc++;
            if (frame_done) got = 1;
        end
        sample_tick = 1'b0;
        if (!got) check("frame_timeout", 0, 1);
        @(negedge clock);
    endtask

    task automatic cfg(input int v, input int st, input int lp, input int pt);
        cfg_write = 1'b1; cfg_voice = 3'(v);
        cfg_start_address = 16'(st); cfg_loop_address = 16'(lp); cfg_pitch = 14'(pt);
        m_start[v] = st; m_loop[v] = lp; m_pitch[v] = pt;
        @(negedge clock);
        cfg_write = 1'b0;
    endtask

    task automatic keys(input logic [NV-1:0] on_m, input logic [NV-1:0] off_m);
        key_on = on_m; key_off = off_m;
        for (int v = 0; v < NV; v++) begin
            if (on_m[v]) m_pon[v] = 1;
            else if (off_m[v]) m_poff[v] = 1;
        end
        @(negedge clock);
        key_on = '0; key_off = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int b;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        model_reset();
        @(negedge clock);
        do_reset();
        check("reset_ram", int'({ram_read_request, ram_address}), 0);
        check("reset_out", int'({out_valid, out_voice, out_sample}), 0);
        check("reset_flags", int'({voice_active, reached_end}), 0);
        check("reset_status", int'({frame_done, busy, overrun}), 0);
        run_frame(-1);

        // Filter 0, range 12: nibbles 1,7 repeated.
        mem[16'h0100] = 8'hC0;
        for (int i = 1; i <= 8; i++) mem[16'h0100 + i] = 8'h17;
        cfg(0, 16'h0100, 0, 14'h1000);
        keys(8'h01, 8'h00);
        repeat (3) run_frame(-1);
        cfg(0, 16'h0100, 0, 14'h0800);
        keys(8'h01, 8'h00);
        repeat (4) run_frame(-1);

        // Filter 1.
        mem[16'h0180] = 8'hC4;
        mem[16'h0181] = 8'h10;
        cfg(0, 16'h0180, 0, 14'h1000);
        keys(8'h01, 8'h00);
        repeat (2) run_frame(-1);

        // End without loop.
        mem[16'h0300] = 8'h01;
        for (int i = 1; i <= 8; i++) mem[16'h0300 + i] = 8'h21;
        cfg(0, 16'h0300, 0, 14'h3FFF);
        keys(8'h01, 8'h00);
        repeat (6) run_frame(-1);
        check("end_active0", int'(voice_active[0]), 0);
        check("end_reached0", int'(reached_end[0]), 1);

        // End with loop to 0x0200.
        mem[16'h0400] = 8'h03;
        for (int i = 1; i <= 8; i++) mem[16'h0400 + i] = 8'h3D;
        mem[16'h0200] = 8'hB8;
        for (int i = 1; i <= 8; i++) mem[16'h0200 + i] = 8'(8'h5A + i);
        cfg(1, 16'h0400, 16'h0200, 14'h3FFF);
        keys(8'h02, 8'h00);
        repeat (8) run_frame(-1);

        // Three-cycle RAM stalls with a tick arriving mid-frame.
        stall_min = 3; stall_max = 3;
        cfg(2, 16'h0200, 16'h0200, 14'h2000);
        keys(8'h04, 8'h00);
        run_frame(10);
        check("overrun_set", int'(overrun), 1);
        run_frame(-1);

        // Randomised voices, blocks, pitches and key traffic.
        stall_min = 0; stall_max = 2;
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < 4; k++) begin
                b = 16'h2000 + v * 16'h0100 + k * 9;
                mem[b] = 8'({4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)), 2'b00});
                if (k == 3) mem[b][1:0] = ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b01;
                for (int i = 1; i <= 8; i++) mem[b + i] = 8'($urandom);
            end
            cfg(v, 16'h2000 + v * 16'h0100, 16'h2000 + v * 16'h0100 + 9, $urandom_range(16383, 0));
        end
        keys(8'hFF, 8'h00);
        for (int f = 0; f < 30; f++) begin
            if (f % 7 == 6) begin
                b = $urandom_range(255, 0);
                keys(8'(b), 8'($urandom_range(255, 0)) & ~8'(b));
            end
            run_frame(-1);
        end

        // Reset in the middle of a frame.
        stall_min = 1; stall_max = 1;
        cfg(3, 16'h2000, 16'h2000, 14'h3FFF);
        keys(8'h08, 8'h00);
        model_frame();
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_req", int'(ram_read_request), 0);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_busy", int'(busy), 0);
        reset = 1'b0;
        model_reset();
        repeat (20) @(negedge clock);
        check("midreset_idle", int'({out_valid, busy, overrun, voice_active}), 0);
        run_frame(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
